// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, sequencer states and
// instruction field extraction that works for any register-address width.
package cpu_pkg;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_BNE  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_JAL  = 4'hF;

    // Widest register address supported by the field helpers.
    localparam int RA_MAX = 8;
    localparam int IW_MAX = 4 + 2 * RA_MAX;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    function automatic logic [RA_MAX-1:0] field_mask(input int ra_w);
        return {RA_MAX{1'b1}} >> (RA_MAX - ra_w);
    endfunction

    function automatic logic [3:0] get_opcode(input logic [IW_MAX-1:0] ir, input int ra_w);
        logic [IW_MAX-1:0] sh;
        sh = ir >> (2 * ra_w);
        return sh[3:0];
    endfunction

    function automatic logic [RA_MAX-1:0] get_ra(input logic [IW_MAX-1:0] ir, input int ra_w);
        logic [IW_MAX-1:0] sh;
        sh = ir >> ra_w;
        return sh[RA_MAX-1:0] & field_mask(ra_w);
    endfunction

    function automatic logic [RA_MAX-1:0] get_rb(input logic [IW_MAX-1:0] ir, input int ra_w);
        logic [IW_MAX-1:0] sh;
        sh = ir;
        return sh[RA_MAX-1:0] & field_mask(ra_w);
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: three asynchronous read ports (two addressed plus r0) and
// one synchronous write port; reset clears every entry.
module regfile #(
    parameter int NREGS  = 4,
    parameter int DATA_W = 8,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   rd_a_addr,
    input  logic [RA_W-1:0]   rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [DATA_W-1:0] rd_0_data,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_r [NREGS];

    assign rd_a_data = regs_r[rd_a_addr];
    assign rd_b_data = regs_r[rd_b_addr];
    assign rd_0_data = regs_r[0];

    // Register storage with clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/MEM/WB sequencer with inline ALU,
// req/ack instruction and data memory ports, sticky overflow and retire pulse.
module multicycle_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8,
    localparam int RA_W  = $clog2(NREGS),
    localparam int IW    = 4 + 2 * RA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [IW-1:0]     imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              halted,
    output logic              retire,
    output logic              overflow
);

    state_e            state_r, state_s;
    logic [PC_W-1:0]   pc_r, npc_r, npc_s, pc_plus1_s, br_tgt_s;
    logic [IW-1:0]     ir_r;
    logic [DATA_W-1:0] a_r, b_r, r0_r, res_r, alu_s, sum_s, diff_s;
    logic [DATA_W-1:0] rf_a_s, rf_b_s, rf_0_s;
    logic [3:0]        op_s;
    logic [RA_W-1:0]   ra_s, rb_s;
    logic              ovf_s, ovf_pend_r, rf_we_s;
    logic              imem_req_r, dmem_req_r, dmem_we_r;
    logic [DATA_W-1:0] dmem_addr_r, dmem_wdata_r;
    logic              halted_r, retire_r, overflow_r;

    assign op_s = get_opcode(IW_MAX'(ir_r), RA_W);
    assign ra_s = RA_W'(get_ra(IW_MAX'(ir_r), RA_W));
    assign rb_s = RA_W'(get_rb(IW_MAX'(ir_r), RA_W));

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign dmem_addr  = dmem_addr_r;
    assign dmem_wdata = dmem_wdata_r;
    assign halted     = halted_r;
    assign retire     = retire_r;
    assign overflow   = overflow_r;

    regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_a_addr (ra_s),
        .rd_b_addr (rb_s),
        .rd_a_data (rf_a_s),
        .rd_b_data (rf_b_s),
        .rd_0_data (rf_0_s),
        .wr_en     (rf_we_s),
        .wr_addr   (ra_s),
        .wr_data   (res_r)
    );

    // Register write enable: only in WB and only for opcodes that produce a result.
    always_comb begin
        rf_we_s = 1'b0;
        if (state_r == WB) begin
            case (op_s)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LW, OP_JAL: rf_we_s = 1'b1;
                default: rf_we_s = 1'b0;
            endcase
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // ALU, overflow detection and next-PC selection from the operands latched in DECODE.
    always_comb begin
        sum_s      = a_r + b_r;
        diff_s     = a_r - b_r;
        pc_plus1_s = pc_r + PC_W'(1'b1);
        // Branch offset is r0 sign-extended (or truncated) to the PC width.
        br_tgt_s   = pc_r + PC_W'($signed(r0_r));
        alu_s      = {DATA_W{1'b0}};
        ovf_s      = 1'b0;
        npc_s      = pc_plus1_s;
        case (op_s)
            OP_ADD: begin
                alu_s = sum_s;
                ovf_s = (a_r[DATA_W-1] == b_r[DATA_W-1]) && (sum_s[DATA_W-1] != a_r[DATA_W-1]);
            end
            OP_SUB: begin
                alu_s = diff_s;
                ovf_s = (a_r[DATA_W-1] != b_r[DATA_W-1]) && (diff_s[DATA_W-1] != a_r[DATA_W-1]);
            end
            OP_AND: alu_s = a_r & b_r;
            OP_OR:  alu_s = a_r | b_r;
            OP_XOR: alu_s = a_r ^ b_r;
            OP_SLT: alu_s = DATA_W'($signed(a_r) < $signed(b_r));
            OP_BEQ: begin
                if (a_r == b_r) npc_s = br_tgt_s;
                else            npc_s = pc_plus1_s;
            end
            OP_BNE: begin
                if (a_r != b_r) npc_s = br_tgt_s;
                else            npc_s = pc_plus1_s;
            end
            OP_JR:  npc_s = PC_W'(a_r);
            OP_JAL: begin
                alu_s = DATA_W'(pc_plus1_s);
                npc_s = PC_W'(b_r);
            end
            default: alu_s = {DATA_W{1'b0}};
        endcase
    end

    // Sequencer next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            FETCH: begin
                if (imem_req_r && imem_ack) state_s = DECODE;
                else                        state_s = FETCH;
            end
            DECODE: begin
                if (op_s == OP_HALT) state_s = HALT;
                else                 state_s = EXEC;
            end
            EXEC: begin
                if (op_s == OP_LW || op_s == OP_SW) state_s = MEM;
                else                                state_s = WB;
            end
            MEM: begin
                if (dmem_req_r && dmem_ack) state_s = WB;
                else                        state_s = MEM;
            end
            WB:      state_s = FETCH;
            HALT:    state_s = HALT;
            default: state_s = FETCH;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= FETCH;
        else        state_r <= state_s;
    end

    // Datapath registers, memory handshakes and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= {PC_W{1'b0}};
            npc_r        <= {PC_W{1'b0}};
            ir_r         <= {IW{1'b0}};
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            r0_r         <= {DATA_W{1'b0}};
            res_r        <= {DATA_W{1'b0}};
            ovf_pend_r   <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            dmem_we_r    <= 1'b0;
            dmem_addr_r  <= {DATA_W{1'b0}};
            dmem_wdata_r <= {DATA_W{1'b0}};
            halted_r     <= 1'b0;
            retire_r     <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            retire_r <= (state_s == WB);
            halted_r <= (state_s == HALT);
            case (state_r)
                FETCH: begin
                    if (imem_req_r && imem_ack) begin
                        ir_r       <= imem_rdata;
                        imem_req_r <= 1'b0;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                DECODE: begin
                    a_r  <= rf_a_s;
                    b_r  <= rf_b_s;
                    r0_r <= rf_0_s;
                end
                EXEC: begin
                    res_r      <= alu_s;
                    npc_r      <= npc_s;
                    ovf_pend_r <= ovf_s;
                    if (state_s == MEM) begin
                        dmem_req_r   <= 1'b1;
                        dmem_we_r    <= (op_s == OP_SW);
                        dmem_addr_r  <= b_r;
                        dmem_wdata_r <= a_r;
                    end
                end
                MEM: begin
                    if (dmem_req_r && dmem_ack) begin
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        if (!dmem_we_r) res_r <= dmem_rdata;
                    end
                end
                WB: begin
                    pc_r <= npc_r;
                    if (ovf_pend_r) overflow_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small programs with behavioural memories
// of configurable ack latency, checked against hand-computed results.
module tb_multicycle_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_rdata;
    logic       dmem_req, dmem_we, dmem_ack;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       halted, retire, overflow;

    logic [7:0] imem_m [256];
    logic [7:0] dmem_m [256];
    int         n_chk, n_fail, cyc, icnt, dcnt, imem_dly, dmem_dly, ret_cnt, stable_err;
    bit         prev_ireq, dack_force;
    logic [7:0] i_addr0, d_addr0, d_wd0;
    logic       d_we0;
    logic [7:0] fetch_q [$];
    int         fetch_cyc_q [$];

    always #5 clk = ~clk;

    multicycle_core #(.DATA_W(8), .NREGS(4), .PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .retire(retire), .overflow(overflow)
    );

    // Memory responders and activity log, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (imem_req) begin
            icnt++;
            if (icnt == 1) i_addr0 = imem_addr;
            else if (imem_addr != i_addr0) stable_err++;
            if (!prev_ireq) begin
                fetch_q.push_back(imem_addr);
                fetch_cyc_q.push_back(cyc);
            end
            imem_ack   = (icnt == imem_dly);
            imem_rdata = imem_m[imem_addr];
        end else begin
            icnt     = 0;
            imem_ack = 1'b0;
        end
        prev_ireq = imem_req;
        if (dmem_req) begin
            dcnt++;
            if (dcnt == 1) begin
                d_addr0 = dmem_addr; d_we0 = dmem_we; d_wd0 = dmem_wdata;
            end else if (dmem_addr != d_addr0 || dmem_we != d_we0 || dmem_wdata != d_wd0) begin
                stable_err++;
            end
            dmem_ack   = (dcnt == dmem_dly);
            dmem_rdata = dmem_m[dmem_addr];
            if (dmem_ack && dmem_we) dmem_m[dmem_addr] = dmem_wdata;
        end else begin
            dcnt     = 0;
            dmem_ack = dack_force;
        end
        if (retire) ret_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem_m[i] = 8'h00;
            dmem_m[i] = 8'h00;
        end
    endtask

    task automatic reset_core(input int idly, input int ddly);
        rst_n = 1'b0;
        imem_dly = idly; dmem_dly = ddly; dack_force = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        fetch_q.delete(); fetch_cyc_q.delete();
        ret_cnt = 0; stable_err = 0;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_status", {halted, retire, overflow}, 3'b000);
        check("rst_pc", imem_addr, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
        check("halted", halted, 1'b1);
    endtask

    task automatic wait_fetches(input int n);
        for (int i = 0; i < 400 && fetch_q.size() < n; i++) @(negedge clk);
        check("fetch_count", fetch_q.size() >= n, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; icnt = 0; dcnt = 0;
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = 8'h00; dmem_rdata = 8'h00;
        prev_ireq = 1'b0; dack_force = 1'b0; ret_cnt = 0; stable_err = 0;

        // LW r1=5, ADD r1,r1, HALT with single-cycle acks.
        clear_mem();
        dmem_m[0] = 8'h05;
        imem_m[0] = 8'hA4; imem_m[1] = 8'h15;
        reset_core(1, 1);
        @(posedge clk); #1;
        check("first_req", imem_req, 1'b1);
        check("first_addr", imem_addr, 8'h00);
        wait_halt();
        check("add_r1", dut.u_regfile.regs_r[1], 8'h0A);
        repeat (3) @(negedge clk);
        check("retire_count", ret_cnt, 2);
        check("lw_cycles", fetch_cyc_q[1] - fetch_cyc_q[0], 6);
        check("add_cycles", fetch_cyc_q[2] - fetch_cyc_q[1], 5);

        // LW/SW/LW with 3-cycle acks on both memories.
        clear_mem();
        dmem_m[0] = 8'h10; dmem_m[8'h10] = 8'h77;
        imem_m[0] = 8'hA4; imem_m[1] = 8'hB5; imem_m[2] = 8'hA9;
        reset_core(3, 3);
        wait_halt();
        check("sw_mem", dmem_m[8'h10], 8'h10);
        check("lw_back", dut.u_regfile.regs_r[2], 8'h10);
        check("slow_lw", fetch_cyc_q[1] - fetch_cyc_q[0], 10);
        check("slow_sw", fetch_cyc_q[2] - fetch_cyc_q[1], 10);
        check("slow_lw2", fetch_cyc_q[3] - fetch_cyc_q[2], 10);
        check("req_stable", stable_err, 0);
        check("slow_retires", ret_cnt, 3);

        // BNE taken with r0=-2 at PC=4.
        clear_mem();
        dmem_m[0] = 8'hFE; dmem_m[8'hFE] = 8'h03; dmem_m[3] = 8'h07;
        imem_m[0] = 8'hA0; imem_m[1] = 8'hA4; imem_m[2] = 8'hA9;
        imem_m[3] = 8'h70; imem_m[4] = 8'hD6;
        reset_core(1, 1);
        wait_fetches(6);
        check("bne_pc4", fetch_q[4], 8'h04);
        check("bne_taken", fetch_q[5], 8'h02);

        // BNE not taken when r1==r2.
        dmem_m[3] = 8'h03;
        reset_core(1, 1);
        wait_fetches(6);
        check("bne_fall", fetch_q[5], 8'h05);
        wait_halt();

        // PC wrap from 0xFF to 0x00 through a NOP.
        clear_mem();
        dmem_m[0] = 8'hFF;
        imem_m[0] = 8'hA4; imem_m[1] = 8'hE4; imem_m[8'hFF] = 8'h70;
        reset_core(1, 1);
        wait_fetches(4);
        check("jr_ff", fetch_q[2], 8'hFF);
        check("pc_wrap", fetch_q[3], 8'h00);

        // Signed overflow is sticky across a later non-overflowing ADD.
        clear_mem();
        dmem_m[0] = 8'h7F; dmem_m[8'h7F] = 8'h01;
        imem_m[0] = 8'hA4; imem_m[1] = 8'hA9; imem_m[2] = 8'h16; imem_m[3] = 8'h1A;
        reset_core(1, 1);
        wait_halt();
        check("ovf_sum", dut.u_regfile.regs_r[1], 8'h80);
        check("ovf_r2", dut.u_regfile.regs_r[2], 8'h02);
        check("ovf_sticky", overflow, 1'b1);

        // JAL r1,r1 with r1=0x20 at PC=0x10.
        clear_mem();
        dmem_m[0] = 8'h10; dmem_m[8'h10] = 8'h20;
        imem_m[0] = 8'hA8; imem_m[1] = 8'hA6; imem_m[2] = 8'hE8; imem_m[8'h10] = 8'hF5;
        reset_core(1, 1);
        wait_halt();
        check("jal_at", fetch_q[3], 8'h10);
        check("jal_tgt", fetch_q[4], 8'h20);
        check("jal_link", dut.u_regfile.regs_r[1], 8'h11);
        check("jal_ovf", overflow, 1'b0);

        // Reset while a store is waiting for its ack.
        clear_mem();
        dmem_m[0] = 8'h09;
        imem_m[0] = 8'hA4; imem_m[1] = 8'hB5;
        reset_core(1, 1);
        for (int i = 0; i < 100 && ret_cnt < 1; i++) @(negedge clk);
        dmem_dly = 1000;
        for (int i = 0; i < 100 && !dmem_req; i++) @(negedge clk);
        check("store_req", dmem_req, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        fetch_q.delete();
        #1;
        check("async_dreq", dmem_req, 1'b0);
        check("async_pc", imem_addr, 8'h00);
        check("async_r1", dut.u_regfile.regs_r[1], 8'h00);
        dack_force = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #2;
        dack_force = 1'b0;
        check("late_ack_dreq", dmem_req, 1'b0);
        check("late_ack_retire", retire, 1'b0);
        wait_fetches(1);
        check("restart_addr", fetch_q[0], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
